reverse_stream: RTL and testbench
=================================

// Module: reverse_stream
// PURPOSE
//   Pipelined, mode-selectable reversal engine on a valid/ready stream: per beat,
//   reverses bit, nibble or byte order of din, or passes it through unchanged.
//   Parametrised successor of the combinational bit reverser.
//   Sits between streaming producers and consumers with full-throughput backpressure
//   (output register plus 1-entry skid buffer).
// PARAMETERS
//   DATA_WIDTH  32  beat width in bits; must be a multiple of 8 and >= 8
//   CNT_WIDTH   16  width of delivered-beat counter
// PORTS
//   clk         in   1           clock, all logic on rising edge
//   reset       in   1           synchronous, active-high reset
//   din         in   DATA_WIDTH  input beat
//   din_mode    in   2           per-beat mode, sampled with din: 00 bit, 01 nibble, 10 byte, 11 pass
//   din_valid   in   1           input beat valid
//   din_ready   out  1           block can accept a beat this cycle
//   dout        out  DATA_WIDTH  transformed beat
//   dout_valid  out  1           dout holds a valid beat
//   dout_ready  in   1           consumer accepts dout this cycle
//   beat_cnt    out  CNT_WIDTH   count of beats delivered (dout_valid & dout_ready)
// BEHAVIOUR
//   Clock and reset:
//   - Single clock.
//   - Reset is synchronous, active-high, and overrides all other activity.
//   - Reset values: dout=0, dout_valid=0, din_ready=1, beat_cnt=0; skid buffer emptied.
//   - Reset mid-operation discards the output beat and the skid beat; neither is counted.
//   Transform (combinational on the input side, applied before registering):
//   - mode 00: out[i] = din[DATA_WIDTH-1-i].
//   - mode 01: nibble k of out = nibble (DATA_WIDTH/4-1-k) of din; bit order inside each nibble kept.
//   - mode 10: byte k of out = byte (DATA_WIDTH/8-1-k) of din; bit order inside each byte kept.
//   - mode 11: out = din.
//   - The transform is applied to each beat exactly once; the mode travels with its beat.
//     Changing din_mode while a beat is stalled does not alter already-accepted beats.
//   Handshake:
//   - Input accepted when din_valid & din_ready.
//   - Output transferred when dout_valid & dout_ready.
//   - din_ready is a registered signal: din_ready = !skid_valid.
//   - Latency: a beat accepted at edge N, with the output register free or draining at edge N,
//     is on dout with dout_valid=1 after edge N (1 cycle).
//   - Throughput: 1 beat/cycle while dout_ready=1.
//   - dout and dout_valid stay stable while dout_valid=1 and dout_ready=0 (AXI-style; no drop, no change).
//   Output register / skid buffer:
//   - Output register empty, or transferring this cycle: an accepted beat loads the output register.
//   - Output register full and not transferring: an accepted beat goes to the skid buffer;
//     din_ready=0 from the next cycle.
//   - On an output transfer with the skid full: the skid beat moves to the output register;
//     the skid becomes empty; din_ready=1 next cycle.
//   - Transfer with the skid empty and no new beat: dout_valid=0 next cycle.
//   - Ordering is strictly FIFO. At most 2 beats are resident.
//   beat_cnt:
//   - Increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
//     No saturation and no sticky overflow.
//   - Updated at the same edge as the transfer.
// TESTING
//   1. bit mode, din=32'h0000_0001 -> dout=32'h8000_0000 one cycle after accept; beat_cnt=1 after transfer.
//   2. Back-to-back beats 32'h1234_5678 in modes 01, 10, 11 with dout_ready=1
//      -> dout 32'h8765_4321, 32'h7856_3412, 32'h1234_5678 on consecutive cycles.
//   3. Backpressure: hold dout_ready=0 and send beats A, B
//      -> A held stable on dout, B in skid, din_ready=0. Raise dout_ready
//      -> A, then B delivered in order, din_ready=1 again.
//   4. Change din_mode from 00 to 10 while a 00-mode beat is stalled
//      -> the stalled beat still emerges bit-reversed.
//   5. Assert reset with both entries full
//      -> next cycle dout_valid=0, dout=0, din_ready=1, beat_cnt=0; no stale beat appears afterwards.
//   6. CNT_WIDTH=4: deliver 17 beats -> beat_cnt reads 15 after beat 15, 0 after beat 16, 1 after beat 17.

Source files
------------

// File: rtl/reverse_stream.sv
// Valid/ready stream stage that reverses bit, nibble or byte order per beat (or passes it through).
// An output register plus a one-entry skid buffer give full throughput under backpressure.
module reverse_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [1:0]            din_mode,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [CNT_WIDTH-1:0]  beat_cnt
);

   localparam int NIBBLES = DATA_WIDTH / 4;
   localparam int BYTES   = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      MODE_BIT    = 2'b00,
      MODE_NIBBLE = 2'b01,
      MODE_BYTE   = 2'b10,
      MODE_PASS   = 2'b11
   } mode_t;

   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_dout_valid;
   logic [DATA_WIDTH-1:0] r_skid;
   logic                  r_skid_valid;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic [DATA_WIDTH-1:0] w_xformed;
   logic                  w_accept;
   logic                  w_xfer;
   mode_t                 w_mode;

   assign w_mode   = mode_t'(din_mode);
   assign w_accept = din_valid & ~r_skid_valid;
   assign w_xfer   = r_dout_valid & dout_ready;

   // Transform is applied once, on the way in, so stalled beats keep the mode they arrived with.
   always_comb begin
      w_xformed = din;
      case (w_mode)
         MODE_BIT: begin
            for (int i = 0; i < DATA_WIDTH; i++)
               w_xformed[i] = din[DATA_WIDTH-1-i];
         end
         MODE_NIBBLE: begin
            for (int k = 0; k < NIBBLES; k++)
               w_xformed[4*k +: 4] = din[4*(NIBBLES-1-k) +: 4];
         end
         MODE_BYTE: begin
            for (int k = 0; k < BYTES; k++)
               w_xformed[8*k +: 8] = din[8*(BYTES-1-k) +: 8];
         end
         default: w_xformed = din;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_skid       <= '0;
         r_skid_valid <= 1'b0;
         r_cnt        <= '0;
      end else begin
         if (w_xfer)
            r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

         // Output slot free or draining: refill from the skid first to keep FIFO order.
         if (!r_dout_valid || w_xfer) begin
            if (r_skid_valid) begin
               r_dout       <= r_skid;
               r_dout_valid <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (w_accept) begin
               r_dout       <= w_xformed;
               r_dout_valid <= 1'b1;
            end else begin
               r_dout_valid <= 1'b0;
            end
         end else if (w_accept) begin
            r_skid       <= w_xformed;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign din_ready  = ~r_skid_valid;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign beat_cnt   = r_cnt;

endmodule

// File: tb/tb_reverse_stream.sv
// Self-checking bench for reverse_stream: directed scenarios plus random traffic
// compared against a queue-based reference model; a CNT_WIDTH=4 twin checks counter wrap.
module tb_reverse_stream;

   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic [DW-1:0] din;
   logic [1:0]    din_mode;
   logic          din_valid;
   logic          dout_ready;

   logic          din_ready,  din_ready_s;
   logic [DW-1:0] dout,       dout_s;
   logic          dout_valid, dout_valid_s;
   logic [15:0]   beat_cnt;
   logic [3:0]    beat_cnt_s;

   int testCount = 0;
   int failCount = 0;

   logic [DW-1:0] expQ[$];
   int            modelCnt = 0;
   int            xferTotal = 0;

   reverse_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .din(din), .din_mode(din_mode), .din_valid(din_valid),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .beat_cnt(beat_cnt)
   );

   reverse_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dutSmall (
      .clk(clk), .reset(reset), .din(din), .din_mode(din_mode), .din_valid(din_valid),
      .din_ready(din_ready_s), .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready),
      .beat_cnt(beat_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference transform written with streaming operators rather than index loops.
   function automatic logic [DW-1:0] refXform(input logic [DW-1:0] d, input logic [1:0] m);
      logic [DW-1:0] r;
      case (m)
         2'b00:   r = {<<{d}};
         2'b01:   r = {<<4{d}};
         2'b10:   r = {<<8{d}};
         default: r = d;
      endcase
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compares every visible output against the model's occupancy, head beat and count.
   task automatic checkState();
      checkOutput("dout_valid", 64'(dout_valid), 64'(expQ.size() > 0));
      checkOutput("din_ready", 64'(din_ready), 64'(expQ.size() < 2));
      if (expQ.size() > 0)
         checkOutput("dout_head", 64'(dout), 64'(expQ[0]));
      checkOutput("beat_cnt", 64'(beat_cnt), 64'(modelCnt % 65536));
      checkOutput("beat_cnt_small", 64'(beat_cnt_s), 64'(modelCnt % 16));
   endtask

   // One clock cycle: drive inputs, let the model observe the handshake, then check after the edge.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                                input logic r);
      bit acc, xf;
      din_valid  = v;
      din        = d;
      din_mode   = m;
      dout_ready = r;
      #1;
      acc = din_valid && (expQ.size() < 2);
      xf  = (expQ.size() > 0) && dout_ready;
      @(posedge clk);
      #1;
      if (xf) begin
         void'(expQ.pop_front());
         modelCnt++;
         xferTotal++;
      end
      if (acc)
         expQ.push_back(refXform(d, m));
      checkState();
   endtask

   task automatic doReset(input logic v, input logic r);
      reset      = 1'b1;
      din_valid  = v;
      din        = 32'hDEAD_BEEF;
      din_mode   = 2'b11;
      dout_ready = r;
      @(posedge clk);
      #1;
      expQ.delete();
      modelCnt = 0;
      checkOutput("rst_dout_valid", 64'(dout_valid), 64'd0);
      checkOutput("rst_dout", 64'(dout), 64'd0);
      checkOutput("rst_din_ready", 64'(din_ready), 64'd1);
      checkOutput("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      checkOutput("rst_beat_cnt_small", 64'(beat_cnt_s), 64'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      din        = '0;
      din_mode   = 2'b00;
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      @(posedge clk);
      doReset(1'b0, 1'b0);

      // Bit mode single beat.
      applyStimulus(1'b1, 32'h0000_0001, 2'b00, 1'b0);
      checkOutput("bit_mode", 64'(dout), 64'h8000_0000);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
      checkOutput("cnt_after_one", 64'(beat_cnt), 64'd1);

      // Back-to-back beats in three modes.
      applyStimulus(1'b1, 32'h1234_5678, 2'b01, 1'b1);
      checkOutput("nibble_mode", 64'(dout), 64'h8765_4321);
      applyStimulus(1'b1, 32'h1234_5678, 2'b10, 1'b1);
      checkOutput("byte_mode", 64'(dout), 64'h7856_3412);
      applyStimulus(1'b1, 32'h1234_5678, 2'b11, 1'b1);
      checkOutput("pass_mode", 64'(dout), 64'h1234_5678);
      applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);

      // Backpressure: A stalls on the output, B lands in the skid.
      applyStimulus(1'b1, 32'hAAAA_0001, 2'b11, 1'b0);
      applyStimulus(1'b1, 32'hBBBB_0002, 2'b11, 1'b0);
      checkOutput("bp_din_ready", 64'(din_ready), 64'd0);
      applyStimulus(1'b1, 32'hCCCC_0003, 2'b11, 1'b0);
      checkOutput("bp_hold_A", 64'(dout), 64'hAAAA_0001);
      applyStimulus(1'b0, 32'h0, 2'b11, 1'b1);
      checkOutput("bp_then_B", 64'(dout), 64'hBBBB_0002);
      checkOutput("bp_ready_back", 64'(din_ready), 64'd1);
      applyStimulus(1'b0, 32'h0, 2'b11, 1'b1);

      // Mode change while a bit-mode beat is stalled.
      applyStimulus(1'b1, 32'h0000_00F1, 2'b00, 1'b0);
      applyStimulus(1'b0, 32'h0000_00F1, 2'b10, 1'b0);
      checkOutput("stall_mode_kept", 64'(dout), 64'h8F00_0000);
      applyStimulus(1'b0, 32'h0, 2'b10, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         applyStimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 9) < 7));

      // Reset with both entries full; nothing stale may appear afterwards.
      applyStimulus(1'b1, 32'h1111_1111, 2'b11, 1'b0);
      applyStimulus(1'b1, 32'h2222_2222, 2'b11, 1'b0);
      checkOutput("full_before_rst", 64'(din_ready), 64'd0);
      doReset(1'b1, 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);

      // Counter wrap on the 4-bit twin.
      xferTotal = 0;
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'(i < 17), 32'(i), 2'b11, 1'b1);
         if (xferTotal == 15 && i == 15) checkOutput("wrap_15", 64'(beat_cnt_s), 64'd15);
         if (xferTotal == 16 && i == 16) checkOutput("wrap_0", 64'(beat_cnt_s), 64'd0);
         if (xferTotal == 17 && i == 17) checkOutput("wrap_1", 64'(beat_cnt_s), 64'd1);
      end
      checkOutput("wrap_total", 64'(xferTotal), 64'd17);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
